pc_fetch_ctrl: RTL and testbench
================================

// Module: pc_fetch_ctrl
// PURPOSE
//  Sequences instruction fetch. Owns the architectural PC, issues word-addressed
//  req/ack reads to instruction memory, and buffers one fetched instruction toward decode.
//  Applies branch/jump redirects using the `PC_ADDR_* encodings from defines.vh.
//  Sits between the hazard unit/ALU branch result and imem; feeds the decode stage.
// PARAMETERS
//  RESET_PC    32'h0  PC loaded on reset (word address)
//  WAIT_LIMIT  255    cycles of req-without-ack before fetch_err sets; 1..65535
// PORTS
//  clk            in   1   clock, all state updates on posedge
//  clr_n          in   1   asynchronous active-low reset
//  stall          in   1   hazard unit: do not start a new fetch
//  redirect_valid in   1   one-cycle redirect strobe from execute
//  redirect_type  in   2   `PC_ADDR_NORMAL / `PC_ADDR_BRANCH / `PC_ADDR_JUMP
//  branch_taken   in   1   ALU branch result, qualifies `PC_ADDR_BRANCH
//  redirect_pc    in   32  PC of the redirecting instruction
//  branch_off     in   32  signed word offset for branches
//  jump_addr      in   32  absolute word target for jumps
//  imem_req       out  1   read request
//  imem_addr      out  32  read word address; stable while imem_req=1 and no ack
//  imem_ack       in   1   read done; imem_rdata valid this cycle
//  imem_rdata     in   32  instruction word
//  fetch_valid    out  1   fetch_instr/fetch_pc valid toward decode
//  fetch_ready    in   1   decode accepts when fetch_valid & fetch_ready
//  fetch_pc       out  32  word address of fetch_instr
//  fetch_instr    out  32  instruction word
//  fetch_err      out  1   sticky watchdog flag
// BEHAVIOUR
//  Reset (clr_n=0, async): state=BOOT, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC,
//   fetch_valid=0, fetch_pc=0, fetch_instr=0, fetch_err=0, wait counter=0.
//  States: BOOT, REQ, HOLD, DRAIN. imem_req=1 in REQ and DRAIN only; imem_addr=pc in REQ.
//  BOOT -> REQ after one cycle with clr_n=1 (stall ignored in BOOT).
//  REQ: on ack: fetch_instr<=rdata, fetch_pc<=pc, fetch_valid<=1, pc<=pc+1, -> HOLD.
//   Zero-wait ack (same cycle req rises) is legal. No ack: stay, addr held.
//  HOLD: slot drains on fetch_valid&fetch_ready (fetch_valid<=0). Go REQ when slot is
//   empty or draining this cycle AND stall=0; else stay. Throughput: 1 instr / 2 cycles.
//  Redirect effective iff redirect_valid & (type==JUMP | (type==BRANCH & branch_taken)).
//   Target: JUMP -> jump_addr; BRANCH -> redirect_pc + 1 + $signed(branch_off), mod 2^32.
//   NORMAL, untaken BRANCH, or type 2'b11: no effect.
//  Effective redirect (priority over stall, ack capture and slot drain): pc<=target,
//   fetch_valid<=0 next cycle. From HOLD -> REQ (stall still applies: HOLD if stall=1).
//   From REQ with ack same cycle: rdata discarded, -> REQ at target.
//   From REQ without ack: -> DRAIN; req stays high at old addr until ack, data discarded,
//   then -> REQ at target (or HOLD if stall=1). Redirect in DRAIN: retarget only.
//  BOOT: redirect ignored.
//  Watchdog: counter increments each cycle imem_req=1 & imem_ack=0, clears on ack;
//   reaching WAIT_LIMIT sets fetch_err=1 until reset. Fetch continues regardless.
//  pc, pc+1, target all wrap mod 2^32 (32'hFFFFFFFF+1 -> 0).
//  Reset mid-operation: outputs to reset values at once; an ack arriving during or right
//   after reset is ignored (imem_req=0).
// TESTING
//  1 Release reset, ack tied 1, ready tied 1 -> imem_addr 0,1,2,3 on REQ cycles; fetch_pc 0,1,2 in order.
//  2 ready=0 after first ack -> fetch_valid=1, fetch_pc=0 held, imem_req=0; ready=1 -> next req addr 1.
//  3 In HOLD: BRANCH, taken, redirect_pc=5, off=32'hFFFFFFFD -> slot flushed, next imem_addr=3.
//  4 REQ addr 7, ack delayed 3 cycles, JUMP to 32'h40 meanwhile -> addr held 7, returned data
//    never valid, next req addr 32'h40.
//  5 WAIT_LIMIT=4, no ack 4 cycles -> fetch_err=1; later acks and fetches proceed, fetch_err stays 1.
//  6 clr_n low mid-REQ at addr 9 -> imem_req=0, fetch_valid=0 at once; release -> refetch from RESET_PC.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: owns the PC, issues req/ack imem reads and holds one fetched instruction for decode.
// Redirects retarget the PC; a redirect during an outstanding read drains that read before refetching.
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0,
    parameter int          WAIT_LIMIT = 255
) (
    input  logic        i_clk,
    input  logic        i_clr_n,
    input  logic        i_stall,
    input  logic        i_redirect_valid,
    input  logic [1:0]  i_redirect_type,
    input  logic        i_branch_taken,
    input  logic [31:0] i_redirect_pc,
    input  logic [31:0] i_branch_off,
    input  logic [31:0] i_jump_addr,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_rdata,
    output logic        o_fetch_valid,
    input  logic        i_fetch_ready,
    output logic [31:0] o_fetch_pc,
    output logic [31:0] o_fetch_instr,
    output logic        o_fetch_err
);
    localparam logic [1:0] PC_ADDR_BRANCH = 2'd1;
    localparam logic [1:0] PC_ADDR_JUMP   = 2'd2;

    typedef enum logic [1:0] {S_BOOT, S_REQ, S_HOLD, S_DRAIN} state_t;

    state_t      r_state, w_state_nx;
    logic [31:0] r_pc, w_pc_nx, r_addr;
    logic        r_valid, w_valid_nx;
    logic [31:0] r_fpc, w_fpc_nx, r_instr, w_instr_nx;
    logic [15:0] r_wait;
    logic        r_err;
    logic        w_redir, w_drain;
    logic [31:0] w_tgt;

    assign w_redir = i_redirect_valid & ((i_redirect_type == PC_ADDR_JUMP) |
                     ((i_redirect_type == PC_ADDR_BRANCH) & i_branch_taken));
    assign w_tgt   = (i_redirect_type == PC_ADDR_JUMP) ? i_jump_addr
                   : i_redirect_pc + 32'd1 + i_branch_off;
    assign w_drain = r_valid & i_fetch_ready;

    assign o_imem_req    = (r_state == S_REQ) | (r_state == S_DRAIN);
    assign o_imem_addr   = r_addr;
    assign o_fetch_valid = r_valid;
    assign o_fetch_pc    = r_fpc;
    assign o_fetch_instr = r_instr;
    assign o_fetch_err   = r_err;

    always_comb begin
        w_state_nx = r_state;
        w_pc_nx    = r_pc;
        w_valid_nx = r_valid;
        w_fpc_nx   = r_fpc;
        w_instr_nx = r_instr;
        case (r_state)
            S_BOOT: w_state_nx = S_REQ;
            S_REQ: begin
                if (w_redir) begin
                    w_pc_nx    = w_tgt;
                    w_valid_nx = 1'b0;
                    w_state_nx = i_imem_ack ? S_REQ : S_DRAIN;
                end else if (i_imem_ack) begin
                    w_instr_nx = i_imem_rdata;
                    w_fpc_nx   = r_pc;
                    w_valid_nx = 1'b1;
                    w_pc_nx    = r_pc + 32'd1;
                    w_state_nx = S_HOLD;
                end
            end
            S_HOLD: begin
                if (w_redir) begin
                    w_pc_nx    = w_tgt;
                    w_valid_nx = 1'b0;
                    w_state_nx = i_stall ? S_HOLD : S_REQ;
                end else begin
                    w_valid_nx = r_valid & ~w_drain;
                    w_state_nx = ((~r_valid | w_drain) & ~i_stall) ? S_REQ : S_HOLD;
                end
            end
            default: begin
                // the in-flight read belongs to the old path: wait it out, never capture it
                w_pc_nx    = w_redir ? w_tgt : r_pc;
                w_state_nx = i_imem_ack ? (i_stall ? S_HOLD : S_REQ) : S_DRAIN;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_clr_n) begin
        if (!i_clr_n) begin
            r_state <= S_BOOT;
            r_pc    <= RESET_PC;
            r_addr  <= RESET_PC;
            r_valid <= 1'b0;
            r_fpc   <= 32'h0;
            r_instr <= 32'h0;
            r_wait  <= 16'h0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_pc    <= w_pc_nx;
            r_addr  <= (w_state_nx == S_REQ) ? w_pc_nx : r_addr;
            r_valid <= w_valid_nx;
            r_fpc   <= w_fpc_nx;
            r_instr <= w_instr_nx;
            if (o_imem_req & ~i_imem_ack) begin
                r_wait <= (r_wait == 16'(WAIT_LIMIT)) ? r_wait : r_wait + 16'd1;
                r_err  <= r_err | (r_wait >= 16'(WAIT_LIMIT - 1));
            end else if (i_imem_ack) begin
                r_wait <= 16'h0;
            end
        end
    end
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: directed scenarios plus randomized traffic, checked every cycle
// against a flag-based model of the fetch slot, outstanding read and PC.
module tb_pc_fetch_ctrl;
    localparam logic [31:0] RPC = 32'h0;
    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        clr_n = 1'b0;
    logic        stall = 1'b0, rv = 1'b0, taken = 1'b0, ack = 1'b0, ready = 1'b1;
    logic [1:0]  rtype = 2'd0;
    logic [31:0] rpc = 32'h0, off = 32'h0, jaddr = 32'h0, rdata = 32'h0;
    logic        req, fvalid, ferr;
    logic [31:0] addr, fpc, finstr;

    int vec = 0, errs = 0;
    bit chk_en = 1'b0;

    pc_fetch_ctrl #(.RESET_PC(RPC), .WAIT_LIMIT(LIMIT)) dut (
        .i_clk(clk), .i_clr_n(clr_n), .i_stall(stall), .i_redirect_valid(rv),
        .i_redirect_type(rtype), .i_branch_taken(taken), .i_redirect_pc(rpc),
        .i_branch_off(off), .i_jump_addr(jaddr), .o_imem_req(req), .o_imem_addr(addr),
        .i_imem_ack(ack), .i_imem_rdata(rdata), .o_fetch_valid(fvalid),
        .i_fetch_ready(ready), .o_fetch_pc(fpc), .o_fetch_instr(finstr), .o_fetch_err(ferr)
    );

    always #5 clk = ~clk;

    // Model: m_boot = first cycle out of reset, m_out = a read is outstanding,
    // m_disc = that read is stale, m_sv/m_spc/m_sin = decode slot contents.
    bit          m_boot = 1'b1, m_out = 1'b0, m_disc = 1'b0, m_sv = 1'b0, m_err = 1'b0;
    logic [31:0] m_pc = RPC, m_addr = RPC, m_spc = 32'h0, m_sin = 32'h0;
    int          m_cnt = 0;

    always @(posedge clk or negedge clr_n) begin
        bit redir;
        logic [31:0] tgt;
        if (!clr_n) begin
            m_boot = 1'b1; m_out = 1'b0; m_disc = 1'b0; m_sv = 1'b0; m_err = 1'b0;
            m_pc = RPC; m_addr = RPC; m_spc = 32'h0; m_sin = 32'h0; m_cnt = 0;
        end else begin
            redir = rv && (rtype == 2'd2 || (rtype == 2'd1 && taken));
            tgt = (rtype == 2'd2) ? jaddr : rpc + 32'd1 + off;
            if (m_out && !ack) begin
                if (m_cnt < LIMIT) m_cnt++;
                if (m_cnt >= LIMIT) m_err = 1'b1;
            end else if (ack) m_cnt = 0;
            if (m_boot) begin
                m_boot = 1'b0; m_out = 1'b1; m_addr = m_pc;
            end else if (m_out) begin
                if (ack) begin
                    if (m_disc) begin
                        m_disc = 1'b0;
                        if (redir) m_pc = tgt;
                        m_out = !stall; m_addr = m_pc;
                    end else if (redir) begin
                        m_pc = tgt; m_addr = tgt;
                    end else begin
                        m_sv = 1'b1; m_spc = m_addr; m_sin = rdata;
                        m_pc = m_addr + 32'd1; m_out = 1'b0;
                    end
                end else if (redir) begin
                    m_pc = tgt; m_disc = 1'b1;
                end
            end else begin
                if (redir) begin m_pc = tgt; m_sv = 1'b0; end
                else if (m_sv && ready) m_sv = 1'b0;
                if (!m_sv && !stall) begin m_out = 1'b1; m_addr = m_pc; end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("req", {31'h0, req}, {31'h0, m_out});
            if (m_out) chk("addr", addr, m_addr);
            chk("valid", {31'h0, fvalid}, {31'h0, m_sv});
            chk("fetch_pc", fpc, m_spc);
            chk("fetch_instr", finstr, m_sin);
            chk("err", {31'h0, ferr}, {31'h0, m_err});
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
        rdata = $urandom;
    endtask

    task automatic quiet();
        stall = 1'b0; rv = 1'b0; rtype = 2'd0; taken = 1'b0;
        rpc = 32'h0; off = 32'h0; jaddr = 32'h0; ack = 1'b0; ready = 1'b1;
    endtask

    task automatic do_reset();
        clr_n = 1'b0;
        quiet();
        tick();
        tick();
        chk_en = 1'b1;
        chk("rst req", {31'h0, req}, 32'h0);
        chk("rst valid", {31'h0, fvalid}, 32'h0);
        chk("rst addr", addr, RPC);
        clr_n = 1'b1;
    endtask

    task automatic jump(input logic [31:0] a);
        rv = 1'b1; rtype = 2'd2; jaddr = a;
    endtask

    initial begin
        // 1: streaming, ack and ready tied high
        do_reset();
        ack = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick(); chk("t1 req", {31'h0, req}, 32'h1); chk("t1 addr", addr, 32'(k));
            tick(); chk("t1 fpc", fpc, 32'(k));
        end
        tick(); chk("t1 addr3", addr, 32'h3);
        // 2: decode back-pressure holds the slot
        do_reset();
        ack = 1'b1; ready = 1'b0;
        tick(); tick();
        repeat (3) begin
            tick();
            chk("t2 valid", {31'h0, fvalid}, 32'h1); chk("t2 fpc", fpc, 32'h0);
            chk("t2 req", {31'h0, req}, 32'h0);
        end
        ready = 1'b1;
        tick(); chk("t2 req1", {31'h0, req}, 32'h1); chk("t2 addr1", addr, 32'h1);
        // 3: taken branch while holding flushes slot
        do_reset();
        ack = 1'b1; ready = 1'b0;
        tick(); tick();
        rv = 1'b1; rtype = 2'd1; taken = 1'b1; rpc = 32'h5; off = 32'hFFFF_FFFD;
        tick(); rv = 1'b0;
        chk("t3 valid", {31'h0, fvalid}, 32'h0); chk("t3 addr", addr, 32'h3);
        // 4: jump during a slow read drains it
        do_reset();
        ack = 1'b1;
        tick(); tick();
        jump(32'h7); ack = 1'b0;
        tick(); rv = 1'b0; chk("t4 addr7", addr, 32'h7);
        tick();
        jump(32'h40);
        tick(); rv = 1'b0; chk("t4 drain addr", addr, 32'h7); chk("t4 drain req", {31'h0, req}, 32'h1);
        tick(); chk("t4 still 7", addr, 32'h7);
        ack = 1'b1;
        tick(); chk("t4 addr40", addr, 32'h40); chk("t4 no valid", {31'h0, fvalid}, 32'h0);
        chk("t4 err", {31'h0, ferr}, 32'h0);
        // 5: watchdog
        do_reset();
        tick(); tick(); tick(); tick();
        chk("t5 err0", {31'h0, ferr}, 32'h0);
        tick(); chk("t5 err1", {31'h0, ferr}, 32'h1);
        ack = 1'b1;
        tick(); chk("t5 fetch", fpc, 32'h0); chk("t5 valid", {31'h0, fvalid}, 32'h1);
        tick(); tick(); chk("t5 sticky", {31'h0, ferr}, 32'h1);
        // 6: reset in the middle of a read
        do_reset();
        ack = 1'b1;
        tick(); tick();
        jump(32'h9); ack = 1'b0;
        tick(); rv = 1'b0; tick(); chk("t6 addr9", addr, 32'h9);
        clr_n = 1'b0; ack = 1'b1;
        #1;
        chk("t6 req0", {31'h0, req}, 32'h0); chk("t6 valid0", {31'h0, fvalid}, 32'h0);
        tick(); tick();
        clr_n = 1'b1;
        tick(); chk("t6 refetch", addr, RPC); chk("t6 req", {31'h0, req}, 32'h1);
        tick(); chk("t6 fpc", fpc, RPC);
        // random traffic
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            tick();
            if (i == 2000) begin
                clr_n = 1'b0; #1; clr_n = 1'b1;
            end
            stall = ($urandom_range(3) == 0);
            rv    = ($urandom_range(9) == 0);
            rtype = 2'($urandom_range(3));
            taken = $urandom_range(1) == 1;
            rpc   = ($urandom_range(7) == 0) ? 32'hFFFF_FFFE : $urandom;
            off   = 32'($urandom_range(16)) - 32'd8;
            jaddr = ($urandom_range(7) == 0) ? 32'hFFFF_FFFF : $urandom;
            ack   = ($urandom_range(9) < 6);
            ready = ($urandom_range(9) < 7);
        end
        tick();
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
